// File: rtl/key_debounce_sched.sv
// Debounce scheduler for active-low push-buttons: one shared counter is
// time-multiplexed across all keys through a round-robin scan.
module key_debounce_sched #(
    parameter int                KEY_NUM = 4,
    parameter int                IDX_W   = 2,
    parameter int                CNT_W   = 20,
    parameter logic [CNT_W-1:0]  CNT_MAX = 20'd999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic               press_flag,
    output logic               release_flag,
    output logic [IDX_W-1:0]   key_idx,
    output logic               busy
);

    localparam int PW = IDX_W + 1;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_NUM-1:0] sync1_q, sync2_q;
    logic [KEY_NUM-1:0] key_state_q, key_state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [IDX_W-1:0]   key_idx_q, key_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               target_q, target_d;
    logic               press_q, press_d;
    logic               release_q, release_d;

    logic [KEY_NUM-1:0] raw_p;
    logic [KEY_NUM-1:0] pending;
    logic               hit_found;
    logic [IDX_W-1:0]   hit_idx;
    logic [PW-1:0]      probe;
    logic               cur_match;
    logic               cnt_done;
    logic [IDX_W-1:0]   cur_next;

    assign raw_p     = ~sync2_q;
    assign pending   = raw_p ^ key_state_q;
    assign cur_match = (raw_p[cur_idx_q] == target_q);
    assign cnt_done  = (cnt_q == CNT_MAX);
    assign cur_next  = (cur_idx_q == IDX_W'(KEY_NUM - 1)) ? '0 : cur_idx_q + 1'b1;

    // First pending key at or after rr_ptr, wrapping modulo KEY_NUM
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        probe     = '0;
        for (int k = 0; k < KEY_NUM; k++) begin
            probe = {1'b0, rr_ptr_q} + PW'(k);
            if (probe >= PW'(KEY_NUM)) begin
                probe = probe - PW'(KEY_NUM);
            end
            if (!hit_found && pending[probe[IDX_W-1:0]]) begin
                hit_found = 1'b1;
                hit_idx   = probe[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= SCAN;
            sync1_q     <= '1;
            sync2_q     <= '1;
            key_state_q <= '0;
            rr_ptr_q    <= '0;
            cur_idx_q   <= '0;
            key_idx_q   <= '0;
            cnt_q       <= '0;
            target_q    <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= key_in;
            sync2_q     <= sync1_q;
            key_state_q <= key_state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_idx_q   <= cur_idx_d;
            key_idx_q   <= key_idx_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN: begin
                if (hit_found) state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!cur_match)    state_d = SCAN;
                else if (cnt_done) state_d = COMMIT;
            end
            COMMIT:  state_d = SCAN;
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        key_state_d = key_state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_idx_d   = cur_idx_q;
        key_idx_d   = key_idx_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        case (state_q)
            SCAN: begin
                if (hit_found) begin
                    cur_idx_d = hit_idx;
                    target_d  = raw_p[hit_idx];
                    cnt_d     = '0;
                end
            end
            DEBOUNCE: begin
                // A bounce hands the counter to the next key in line
                if (!cur_match) begin
                    cnt_d    = '0;
                    rr_ptr_d = cur_next;
                end else if (!cnt_done) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMMIT: begin
                key_state_d[cur_idx_q] = target_q;
                key_idx_d              = cur_idx_q;
                press_d                = target_q;
                release_d              = ~target_q;
                rr_ptr_d               = cur_next;
            end
            default: ;
        endcase
    end

    assign key_state    = key_state_q;
    assign press_flag   = press_q;
    assign release_flag = release_q;
    assign key_idx      = key_idx_q;
    assign busy         = (state_q != SCAN);

endmodule

// File: tb/tb_key_debounce_sched.sv
// Bench for key_debounce_sched with a short debounce window (CNT_MAX = 3),
// directed scenarios plus random key activity checked against a reference model.
module tb_key_debounce_sched;

    localparam int KN = 4;
    localparam int IW = 2;
    localparam int CM = 3;

    logic          sys_clk;
    logic          sys_rst_n;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_state;
    logic          press_flag;
    logic          release_flag;
    logic [IW-1:0] key_idx;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;

    key_debounce_sched #(
        .KEY_NUM (KN),
        .IDX_W   (IW),
        .CNT_W   (20),
        .CNT_MAX (20'd3)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_in       (key_in),
        .key_state    (key_state),
        .press_flag   (press_flag),
        .release_flag (release_flag),
        .key_idx      (key_idx),
        .busy         (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [8:0] obs;
    assign obs = {press_flag, release_flag, key_idx, key_state, busy};

    // Reference model: pressed levels seen through two sample delays, committed
    // levels, the key holding the shared counter (-1 = none) and its hold time.
    bit m_s1 [KN];
    bit m_s2 [KN];
    bit m_comm [KN];
    int m_sel, m_hold, m_rr, m_last;
    bit m_want, m_in_commit, m_press, m_rel;

    function automatic void model_reset();
        for (int i = 0; i < KN; i++) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_comm[i] = 1'b0;
        end
        m_sel = -1; m_hold = 0; m_rr = 0; m_last = 0;
        m_want = 1'b0; m_in_commit = 1'b0; m_press = 1'b0; m_rel = 1'b0;
    endfunction

    function automatic void model_step();
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (m_sel < 0) begin
            for (int k = 0; k < KN; k++) begin
                int i = (m_rr + k) % KN;
                if (m_sel < 0 && m_s2[i] != m_comm[i]) begin
                    m_sel = i; m_want = m_s2[i]; m_hold = 0; m_in_commit = 1'b0;
                end
            end
        end else if (m_in_commit) begin
            m_comm[m_sel] = m_want;
            m_press = m_want;
            m_rel   = !m_want;
            m_last  = m_sel;
            m_rr    = (m_sel + 1) % KN;
            m_sel   = -1;
        end else if (m_s2[m_sel] != m_want) begin
            m_rr  = (m_sel + 1) % KN;
            m_sel = -1;
        end else if (m_hold == CM) begin
            m_in_commit = 1'b1;
        end else begin
            m_hold = m_hold + 1;
        end
        for (int i = 0; i < KN; i++) begin
            m_s2[i] = m_s1[i];
            m_s1[i] = !key_in[i];
        end
    endfunction

    function automatic logic [8:0] exp_vec();
        logic [KN-1:0] c;
        for (int i = 0; i < KN; i++) c[i] = m_comm[i];
        return {m_press, m_rel, IW'(m_last), c, (m_sel >= 0)};
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) model_reset();
        else            model_step();
    end

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        key_in    = '1;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        key_in    = '1;
        @(negedge sys_clk);
        n_checks++;
        if (obs !== 9'b0) begin
            n_err++; $display("FAIL reset_values: got %b expected %b", obs, 9'b0);
        end
        sys_rst_n = 1'b1;
        repeat (4) begin
            @(negedge sys_clk);
            n_checks++;
            if (obs !== 9'b0 || obs !== exp_vec()) begin
                n_err++; $display("FAIL reset_idle: got %b expected %b", obs, exp_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        logic [8:0] want;
        @(negedge sys_clk);
        key_in[2] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(posedge sys_clk); #1;
            want = {(e == 7), 1'b0, (e >= 7) ? 2'd2 : 2'd0,
                    (e >= 7) ? 4'b0100 : 4'b0000, (e >= 2 && e <= 6)};
            n_checks++;
            if (obs !== want || obs !== exp_vec()) begin
                n_err++; $display("FAIL clean_press E%0d: got %b expected %b model %b", e, obs, want, exp_vec());
            end
        end
    endtask

    task automatic test_release();
        logic [8:0] want;
        @(negedge sys_clk);
        key_in[2] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge sys_clk); #1;
            want = {1'b0, (e == 7), 2'd2, (e >= 7) ? 4'b0000 : 4'b0100, (e >= 2 && e <= 6)};
            n_checks++;
            if (obs !== want || obs !== exp_vec()) begin
                n_err++; $display("FAIL release E%0d: got %b expected %b model %b", e, obs, want, exp_vec());
            end
        end
    endtask

    task automatic test_bounce();
        int presses = 0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                key_in[1] = (c >= 3);
                @(negedge sys_clk);
                n_checks++;
                if (press_flag !== 1'b0 || release_flag !== 1'b0 || obs !== exp_vec()) begin
                    n_err++; $display("FAIL bounce_quiet r%0d c%0d: got %b expected %b", r, c, obs, exp_vec());
                end
            end
        end
        key_in[1] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            if (press_flag && key_idx == 2'd1) presses++;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL bounce_hold c%0d: got %b expected %b", c, obs, exp_vec());
            end
        end
        n_checks++;
        if (presses != 1 || key_state[1] !== 1'b1) begin
            n_err++; $display("FAIL bounce_result: presses=%0d state=%b expected presses=1 state[1]=1", presses, key_state);
        end
    endtask

    task automatic test_simultaneous();
        logic [8:0] want;
        apply_reset();
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        for (int e = 0; e < 16; e++) begin
            @(posedge sys_clk); #1;
            want[8]   = (e == 7) || (e == 13);
            want[7]   = 1'b0;
            want[6:5] = (e >= 13) ? 2'd3 : 2'd0;
            want[4:1] = (e >= 13) ? 4'b1001 : (e >= 7) ? 4'b0001 : 4'b0000;
            want[0]   = (e >= 2 && e <= 6) || (e >= 8 && e <= 12);
            n_checks++;
            if (obs !== want || obs !== exp_vec()) begin
                n_err++; $display("FAIL simultaneous E%0d: got %b expected %b model %b", e, obs, want, exp_vec());
            end
        end
    endtask

    task automatic test_fairness();
        int hold0 = 0, hold1 = 0;
        int seen = -1;
        apply_reset();
        key_in[2] = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (hold0 == 0) begin key_in[0] = ~key_in[0]; hold0 = $urandom_range(1, 3); end
            if (hold1 == 0) begin key_in[1] = ~key_in[1]; hold1 = $urandom_range(1, 3); end
            hold0--; hold1--;
            @(negedge sys_clk);
            if (press_flag && key_idx == 2'd2 && seen < 0) seen = c;
            n_checks++;
            if (obs !== exp_vec() || ((press_flag || release_flag) && key_idx !== 2'd2)) begin
                n_err++; $display("FAIL fairness c%0d: got %b expected %b", c, obs, exp_vec());
            end
        end
        n_checks++;
        if (seen < 0 || seen > 60 || key_state[2] !== 1'b1) begin
            n_err++; $display("FAIL fairness_service: key2 press at cycle %0d state=%b expected within 60 cycles", seen, key_state);
        end
        key_in[1:0] = 2'b11;
        repeat (20) @(negedge sys_clk);
    endtask

    task automatic test_reset_mid();
        logic [8:0] want;
        apply_reset();
        key_in[1] = 1'b0;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 9'b0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL reset_mid_clear: got %b expected %b", obs, 9'b0);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge sys_clk); #1;
            want = {(e == 7), 1'b0, (e >= 7) ? 2'd1 : 2'd0,
                    (e >= 7) ? 4'b0010 : 4'b0000, (e >= 2 && e <= 6)};
            n_checks++;
            if (obs !== want || obs !== exp_vec()) begin
                n_err++; $display("FAIL reset_mid_redo E%0d: got %b expected %b model %b", e, obs, want, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int hold [KN];
        apply_reset();
        for (int i = 0; i < KN; i++) hold[i] = $urandom_range(1, 12);
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < KN; i++) begin
                if (hold[i] == 0) begin
                    if ($urandom_range(0, 1) == 1) key_in[i] = ~key_in[i];
                    hold[i] = $urandom_range(1, 12);
                end
                hold[i]--;
            end
            @(negedge sys_clk);
            n_checks++;
            if (obs !== exp_vec() || (press_flag && release_flag)) begin
                n_err++; $display("FAIL random c%0d: got %b expected %b", c, obs, exp_vec());
            end
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_in    = '1;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
